dvfs_error_tracker: RTL and testbench

Multi-channel, pipelined successor to the combinational sensor/target error block. It accepts time-multiplexed per-channel performance samples and computes the signed and absolute error against each target. It smooths the error with a per-channel exponential moving average and steps a per-channel DVFS level up or down, with hysteresis and a hold-off interval. It sits between the sensor aggregation logic and the voltage/frequency level registers.

---
 rtl/dvfs_error_tracker.sv | 152 +++++++++++++++
 tb/tb_dvfs_error_tracker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dvfs_error_tracker.sv
`default_nettype none
// ============================================================================
// Module      : dvfs_error_tracker
// Description : Multi-channel pipelined sensor/target error tracker with
//               per-channel EMA filter and hysteretic DVFS level stepping.
// Revision    : 1.0 - initial release
// ============================================================================
module dvfs_error_tracker #(
  parameter int NCH      = 4,
  parameter int DW       = 16,
  parameter int NLVL     = 8,
  parameter int INIT_LVL = 3,
  parameter int ALPHA_SH = 2,
  parameter int HYST     = 16,
  parameter int HOLD     = 2,
  parameter int CHW      = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int LVLW     = $clog2(NLVL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_clear,
  input  logic                  in_valid,
  input  logic [CHW-1:0]        in_ch,
  input  logic [DW-1:0]         sensor_data,
  input  logic [DW-1:0]         target_performance,
  output logic                  out_valid,
  output logic [CHW-1:0]        out_ch,
  output logic [DW-1:0]         abs_err,
  output logic [DW:0]           filt_err,
  output logic                  lvl_up,
  output logic                  lvl_dn,
  output logic [NCH*LVLW-1:0]   level_vec,
  output logic                  ch_err
);

  localparam int                     c_hw      = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [c_hw-1:0]        c_hold    = c_hw'(HOLD);
  localparam logic [LVLW-1:0]        c_init    = LVLW'(INIT_LVL);
  localparam logic [LVLW-1:0]        c_lvl_max = LVLW'(NLVL - 1);
  localparam logic signed [DW+1:0]   c_hyst    = $signed((DW+2)'(HYST));

  // Stage 1: signed error and magnitude
  logic                   w_ch_ok;
  logic signed [DW:0]     w_diff;
  logic        [DW:0]     w_neg;
  logic        [DW-1:0]   w_abs;

  logic                   r_s1_valid;
  logic [CHW-1:0]         r_s1_ch;
  logic signed [DW:0]     r_s1_diff;
  logic [DW-1:0]          r_s1_abs;

  assign w_ch_ok = (int'(in_ch) < NCH);
  assign w_diff  = $signed({1'b0, target_performance}) - $signed({1'b0, sensor_data});
  assign w_neg   = -w_diff;
  assign w_abs   = w_diff[DW] ? w_neg[DW-1:0] : w_diff[DW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_diff  <= '0;
      r_s1_abs   <= '0;
      ch_err     <= 1'b0;
    end else begin
      r_s1_valid <= in_valid & w_ch_ok & ~soft_clear;
      ch_err     <= in_valid & ~w_ch_ok & ~soft_clear;
      if (in_valid && w_ch_ok) begin
        r_s1_ch   <= in_ch;
        r_s1_diff <= w_diff;
        r_s1_abs  <= w_abs;
      end
    end
  end

  // Per-channel state; stage 2 reads the entry it wrote last cycle, so no bypass
  logic signed [DW:0]     r_filt [NCH];
  logic [c_hw-1:0]        r_hold [NCH];
  logic [LVLW-1:0]        r_lvl  [NCH];

  logic signed [DW:0]     w_f_cur;
  logic signed [DW+1:0]   w_f_ext;
  logic signed [DW+1:0]   w_d_ext;
  logic signed [DW+1:0]   w_delta;
  logic signed [DW+1:0]   w_sum;
  logic signed [DW:0]     w_f_new;
  logic [LVLW-1:0]        w_lvl_cur;
  logic                   w_busy;
  logic                   w_up;
  logic                   w_dn;

  assign w_f_cur   = r_filt[r_s1_ch];
  assign w_f_ext   = {w_f_cur[DW], w_f_cur};
  assign w_d_ext   = {r_s1_diff[DW], r_s1_diff};
  assign w_delta   = w_d_ext - w_f_ext;
  assign w_sum     = w_f_ext + (w_delta >>> ALPHA_SH);
  assign w_f_new   = w_sum[DW:0];
  assign w_lvl_cur = r_lvl[r_s1_ch];
  assign w_busy    = (r_hold[r_s1_ch] != '0);
  assign w_up      = ~w_busy & (w_sum > c_hyst) & (w_lvl_cur < c_lvl_max);
  assign w_dn      = ~w_busy & (w_sum < -c_hyst) & (w_lvl_cur != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_filt[i] <= '0;
        r_hold[i] <= '0;
        r_lvl[i]  <= c_init;
      end
      out_valid <= 1'b0;
      out_ch    <= '0;
      abs_err   <= '0;
      filt_err  <= '0;
      lvl_up    <= 1'b0;
      lvl_dn    <= 1'b0;
    end else if (soft_clear) begin
      for (int i = 0; i < NCH; i++) begin
        r_filt[i] <= '0;
        r_hold[i] <= '0;
        r_lvl[i]  <= c_init;
      end
      out_valid <= 1'b0;
      lvl_up    <= 1'b0;
      lvl_dn    <= 1'b0;
    end else begin
      out_valid <= r_s1_valid;
      lvl_up    <= r_s1_valid & w_up;
      lvl_dn    <= r_s1_valid & w_dn;
      if (r_s1_valid) begin
        out_ch            <= r_s1_ch;
        abs_err           <= r_s1_abs;
        filt_err          <= w_f_new;
        r_filt[r_s1_ch]   <= w_f_new;
        if (w_busy) begin
          r_hold[r_s1_ch] <= r_hold[r_s1_ch] - c_hw'(1);
        end else if (w_up) begin
          r_lvl[r_s1_ch]  <= w_lvl_cur + LVLW'(1);
          r_hold[r_s1_ch] <= c_hold;
        end else if (w_dn) begin
          r_lvl[r_s1_ch]  <= w_lvl_cur - LVLW'(1);
          r_hold[r_s1_ch] <= c_hold;
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lvl
    assign level_vec[g*LVLW +: LVLW] = r_lvl[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_dvfs_error_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_dvfs_error_tracker
// Description : Scoreboard bench for dvfs_error_tracker (NCH=5 build, CHW=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dvfs_error_tracker;

  localparam int NCH = 5, DW = 16, NLVL = 8, INIT_LVL = 3;
  localparam int ALPHA_SH = 2, HYST = 16, HOLD = 2, CHW = 3, LVLW = 3;
  localparam logic [NCH*LVLW-1:0] c_reset_vec = 15'h36DB;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 soft_clear = 1'b0;
  logic                 in_valid = 1'b0;
  logic [CHW-1:0]       in_ch = '0;
  logic [DW-1:0]        sensor_data = '0;
  logic [DW-1:0]        target_performance = '0;
  logic                 out_valid;
  logic [CHW-1:0]       out_ch;
  logic [DW-1:0]        abs_err;
  logic [DW:0]          filt_err;
  logic                 lvl_up;
  logic                 lvl_dn;
  logic [NCH*LVLW-1:0]  level_vec;
  logic                 ch_err;

  dvfs_error_tracker #(
    .NCH(NCH), .DW(DW), .NLVL(NLVL), .INIT_LVL(INIT_LVL), .ALPHA_SH(ALPHA_SH),
    .HYST(HYST), .HOLD(HOLD), .CHW(CHW), .LVLW(LVLW)
  ) dut (
    .clk(clk), .rst(rst), .soft_clear(soft_clear), .in_valid(in_valid),
    .in_ch(in_ch), .sensor_data(sensor_data), .target_performance(target_performance),
    .out_valid(out_valid), .out_ch(out_ch), .abs_err(abs_err), .filt_err(filt_err),
    .lvl_up(lvl_up), .lvl_dn(lvl_dn), .level_vec(level_vec), .ch_err(ch_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                  cyc;
    int                  ch;
    int                  abs_v;
    int                  filt;
    bit                  up;
    bit                  dn;
    logic [NCH*LVLW-1:0] lv;
  } exp_t;

  exp_t sb[$];
  int   cq[$];
  int   total = 0;
  int   bad = 0;
  int   mf[NCH];
  int   mh[NCH];
  int   ml[NCH];

  task automatic chk(input string nm, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      mf[i] = 0;
      mh[i] = 0;
      ml[i] = INIT_LVL;
    end
  endfunction

  function automatic logic [NCH*LVLW-1:0] pack();
    logic [NCH*LVLW-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*LVLW +: LVLW] = LVLW'(ml[i]);
    return v;
  endfunction

  task automatic issue(input int ch, input int s, input int t, input bit clr);
    exp_t e;
    int   d, f, fn;
    bit   up, dn;
    @(posedge clk); #1;
    in_valid = 1'b1; in_ch = CHW'(ch); soft_clear = clr;
    sensor_data = DW'(s); target_performance = DW'(t);
    if (clr) begin
      model_reset();
    end else if (ch >= NCH) begin
      cq.push_back(cyc + 1);
    end else begin
      d = t - s; f = mf[ch]; fn = f + ((d - f) >>> ALPHA_SH);
      up = 1'b0; dn = 1'b0;
      if (mh[ch] != 0) mh[ch]--;
      else if (fn > HYST && ml[ch] < NLVL - 1) begin ml[ch]++; up = 1'b1; mh[ch] = HOLD; end
      else if (fn < -HYST && ml[ch] > 0) begin ml[ch]--; dn = 1'b1; mh[ch] = HOLD; end
      mf[ch] = fn;
      e.cyc = cyc + 2; e.ch = ch; e.abs_v = (d < 0) ? -d : d; e.filt = fn;
      e.up = up; e.dn = dn; e.lv = pack();
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0; soft_clear = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (sb.size() > 0 || cq.size() > 0); i++) idle(1);
    idle(2);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin : mon
    exp_t e;
    bit   ex;
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e = sb.pop_front();
          chk("latency", cyc, e.cyc);
          chk("out_ch", out_ch, e.ch);
          chk("abs_err", abs_err, e.abs_v);
          chk("filt_err", int'($signed(filt_err)), e.filt);
          chk("lvl_up", lvl_up, e.up);
          chk("lvl_dn", lvl_dn, e.dn);
          chk("level_vec", level_vec, e.lv);
        end
      end else begin
        chk("idle_pulses", {lvl_up, lvl_dn}, 0);
      end
      ex = (cq.size() > 0 && cq[0] == cyc);
      if (ex) void'(cq.pop_front());
      if (ex || ch_err) chk("ch_err", ch_err, ex);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(5);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_level_vec", level_vec, c_reset_vec);
    chk("reset_abs_err", abs_err, 0);
    chk("reset_filt_err", filt_err, 0);

    issue(0, 100, 100, 0);
    idle(1);
    // ch1 at +400 error: filter 100,175,231,273; up on samples 1,4,7,10
    for (int i = 0; i < 4; i++) issue(1, 0, 400, 0);
    drain();
    chk("ch1_level_after4", level_vec[5:3], 5);
    for (int i = 0; i < 10; i++) issue(1, 0, 400, 0);
    drain();
    chk("ch1_level_limit", level_vec[5:3], 7);
    for (int i = 0; i < 4; i++) issue(1, 16'hFFFF, 0, 0);
    drain();

    for (int i = 0; i < 3; i++) begin
      issue(2, 0, 1000, 0);
      issue(3, 1000, 0, 0);
    end
    drain();
    chk("ch0_level_unchanged", level_vec[2:0], 3);
    chk("ch2_level", level_vec[8:6], 4);
    chk("ch3_level", level_vec[11:9], 2);

    // ch0: f'=16 sits on the dead-band edge, f'=17 crosses it
    issue(0, 0, 64, 0);
    issue(0, 0, 20, 0);
    drain();
    chk("ch0_hyst_edge", level_vec[2:0], 4);

    issue(5, 1, 2, 0);
    issue(4, 10, 50, 0);
    issue(7, 3, 4, 0);
    drain();

    issue(1, 0, 400, 1);
    idle(1);
    chk("clear_level_vec", level_vec, c_reset_vec);
    drain();

    issue(2, 0, 1000, 0);
    idle(1);
    @(posedge clk); #2;
    chk("pre_reset_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_reset_out_valid", out_valid, 0);
    chk("async_reset_level_vec", level_vec, c_reset_vec);
    sb.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    chk("sb_empty", sb.size(), 0);
    chk("cherr_q_empty", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
